// File: rtl/obstacle_scroller.sv
// obstacle_scroller
//   Scrolling-obstacle position engine for the Flappy VGA datapath. Holds N
//   obstacles (left/right X edges), scrolls them left by `speed` pixels on each
//   frame tick, respawns them at SCREEN_W when they leave the screen, tracks
//   the obstacle in scope of the bird and counts passed obstacles as score.
//
//   Ports:
//     clk        system clock
//     reset      asynchronous active-low reset
//     start      INIT -> RUN
//     stop       RUN/PAUSE -> STOP (end of game)
//     ack        STOP -> INIT
//     pause      level; RUN <-> PAUSE
//     tick       one-cycle frame/move strobe
//     speed      pixels moved per tick (0 = no motion)
//     edge_l     left edges ordered by scope, slot k = obstacle (cur_idx+k) mod N
//     edge_r     right edges, same ordering
//     cur_idx    index of the obstacle currently in scope
//     score      saturating passed-obstacle count
//     pass_pulse one-cycle strobe per pass
//     q_init/q_run/q_pause/q_stop  one-hot state flags
module obstacle_scroller #(
  parameter int unsigned N        = 5,
  parameter int unsigned XW       = 10,
  parameter int unsigned OBJ_W    = 61,
  parameter int unsigned INTERVAL = 142,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned BIRD_X   = 230,
  parameter int unsigned INIT_IDX = 2,
  parameter int unsigned SCORE_W  = 8,
  parameter int unsigned SPEED_W  = 3,
  localparam int unsigned IW      = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 ack,
  input  logic                 pause,
  input  logic                 tick,
  input  logic [SPEED_W-1:0]   speed,
  output logic [N*XW-1:0]      edge_l,
  output logic [N*XW-1:0]      edge_r,
  output logic [IW-1:0]        cur_idx,
  output logic [SCORE_W-1:0]   score,
  output logic                 pass_pulse,
  output logic                 q_init,
  output logic                 q_run,
  output logic                 q_pause,
  output logic                 q_stop
);

  typedef enum logic [3:0] {
    S_INIT  = 4'b0001,
    S_RUN   = 4'b0010,
    S_PAUSE = 4'b0100,
    S_STOP  = 4'b1000
  } state_t;

  state_t state_q, state_d;

  logic [XW-1:0]      left_q  [N];
  logic [XW-1:0]      right_q [N];
  logic [XW-1:0]      left_d  [N];
  logic [XW-1:0]      right_d [N];
  logic [IW-1:0]      cur_q, cur_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               pulse_q, pulse_d;

  logic [XW-1:0]      step;
  logic [XW-1:0]      cur_right;
  logic [IW-1:0]      cur_next;

  function automatic logic [XW-1:0] init_left(input int unsigned i);
    return XW'(i * INTERVAL);
  endfunction

  function automatic logic [XW-1:0] init_right(input int unsigned i);
    return XW'(i * INTERVAL + OBJ_W);
  endfunction

  assign step = XW'(speed);

  // Right edge of the in-scope obstacle, taken from the registered values so
  // pass detection sees the position from before this tick's move.
  always_comb begin
    cur_right = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (cur_q == IW'(i)) cur_right = right_q[i];
    end
  end

  assign cur_next = (cur_q == IW'(N - 1)) ? '0 : cur_q + IW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_INIT;
      for (int unsigned i = 0; i < N; i++) begin
        left_q[i]  <= init_left(i);
        right_q[i] <= init_right(i);
      end
      cur_q   <= IW'(INIT_IDX);
      score_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      right_q <= right_d;
      cur_q   <= cur_d;
      score_q <= score_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    left_d  = left_q;
    right_d = right_q;
    cur_d   = cur_q;
    score_d = score_q;
    pulse_d = 1'b0;
    case (state_q)
      S_INIT: begin
        for (int unsigned i = 0; i < N; i++) begin
          left_d[i]  = init_left(i);
          right_d[i] = init_right(i);
        end
        cur_d   = IW'(INIT_IDX);
        score_d = '0;
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_STOP;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (tick) begin
          for (int unsigned i = 0; i < N; i++) begin
            if (right_q[i] <= step) begin
              left_d[i]  = XW'(SCREEN_W);
              right_d[i] = XW'(SCREEN_W + OBJ_W);
            end else begin
              right_d[i] = right_q[i] - step;
              left_d[i]  = (left_q[i] >= step) ? left_q[i] - step : '0;
            end
          end
          if (cur_right < XW'(BIRD_X)) begin
            cur_d   = cur_next;
            score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
            pulse_d = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (stop)        state_d = S_STOP;
        else if (!pause) state_d = S_RUN;
      end
      S_STOP: begin
        if (ack) state_d = S_INIT;
      end
      default: begin
        // Illegal one-hot code: go back to INIT with a clean reload.
        state_d = S_INIT;
        for (int unsigned i = 0; i < N; i++) begin
          left_d[i]  = init_left(i);
          right_d[i] = init_right(i);
        end
        cur_d   = IW'(INIT_IDX);
        score_d = '0;
      end
    endcase
  end

  // Rotate the edge buses so slot 0 is always the in-scope obstacle.
  always_comb begin
    edge_l = '0;
    edge_r = '0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if ((32'(cur_q) + k == i) || (32'(cur_q) + k == i + N)) begin
          edge_l[k*XW +: XW] = left_q[i];
          edge_r[k*XW +: XW] = right_q[i];
        end
      end
    end
  end

  assign cur_idx    = cur_q;
  assign score      = score_q;
  assign pass_pulse = pulse_q;
  assign q_init     = (state_q == S_INIT);
  assign q_run      = (state_q == S_RUN);
  assign q_pause    = (state_q == S_PAUSE);
  assign q_stop     = (state_q == S_STOP);

endmodule

// File: tb/tb_obstacle_scroller.sv
module tb_obstacle_scroller;
  localparam int N  = 5;
  localparam int XW = 10;
  localparam int SW = 2;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, stop = 1'b0, ack = 1'b0, pause = 1'b0, tick = 1'b0;
  logic [2:0] speed = '0;
  logic [N*XW-1:0] edge_l, edge_r;
  logic [IW-1:0] cur_idx;
  logic [SW-1:0] score;
  logic pass_pulse, q_init, q_run, q_pause, q_stop;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  obstacle_scroller #(.N(N), .XW(XW), .SCORE_W(SW)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .ack(ack),
    .pause(pause), .tick(tick), .speed(speed), .edge_l(edge_l),
    .edge_r(edge_r), .cur_idx(cur_idx), .score(score),
    .pass_pulse(pass_pulse), .q_init(q_init), .q_run(q_run),
    .q_pause(q_pause), .q_stop(q_stop)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  localparam int M_INIT = 0, M_RUN = 1, M_PAUSE = 2, M_STOP = 3;
  int mL[N];
  int mR[N];
  int mcur, mscore, mst;
  bit mpulse;

  task automatic m_reload();
    for (int i = 0; i < N; i++) begin
      mL[i] = i * 142;
      mR[i] = i * 142 + 61;
    end
    mcur = 2;
    mscore = 0;
  endtask

  task automatic m_step();
    int st;
    bit passed;
    if (!reset) begin
      m_reload();
      mst = M_INIT;
      mpulse = 1'b0;
      return;
    end
    mpulse = 1'b0;
    case (mst)
      M_INIT: begin
        m_reload();
        if (start) mst = M_RUN;
      end
      M_RUN: begin
        if (stop) mst = M_STOP;
        else if (pause) mst = M_PAUSE;
        else if (tick) begin
          st = int'(speed);
          passed = (mR[mcur] < 230);
          for (int i = 0; i < N; i++) begin
            if (mR[i] <= st) begin
              mL[i] = 640;
              mR[i] = 701;
            end else begin
              mR[i] = mR[i] - st;
              mL[i] = (mL[i] > st) ? mL[i] - st : 0;
            end
          end
          if (passed) begin
            mcur = (mcur + 1) % N;
            if (mscore < 3) mscore = mscore + 1;
            mpulse = 1'b1;
          end
        end
      end
      M_PAUSE: begin
        if (stop) mst = M_STOP;
        else if (!pause) mst = M_RUN;
      end
      default: if (ack) mst = M_INIT;
    endcase
  endtask

  initial begin
    m_reload();
    mst = M_INIT;
    mpulse = 1'b0;
    forever begin
      @(posedge clk or negedge reset);
      m_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic [N*XW-1:0] eL, eR;
    logic [3:0] eq, aq;
    #1;
    if (chk_en) begin
      eL = '0;
      eR = '0;
      for (int k = 0; k < N; k++) begin
        eL[k*XW +: XW] = XW'(mL[(mcur + k) % N]);
        eR[k*XW +: XW] = XW'(mR[(mcur + k) % N]);
      end
      eq = 4'b0001 << mst;
      aq = {q_stop, q_pause, q_run, q_init};
      total++;
      if (edge_l !== eL) begin bad++; $display("FAIL model_edge_l got=%h want=%h t=%0t", edge_l, eL, $time); end
      total++;
      if (edge_r !== eR) begin bad++; $display("FAIL model_edge_r got=%h want=%h t=%0t", edge_r, eR, $time); end
      total++;
      if (int'(cur_idx) != mcur) begin bad++; $display("FAIL model_cur got=%0d want=%0d t=%0t", cur_idx, mcur, $time); end
      total++;
      if (int'(score) != mscore) begin bad++; $display("FAIL model_score got=%0d want=%0d t=%0t", score, mscore, $time); end
      total++;
      if (pass_pulse !== mpulse) begin bad++; $display("FAIL model_pulse got=%0b want=%0b t=%0t", pass_pulse, mpulse, $time); end
      total++;
      if (aq !== eq) begin bad++; $display("FAIL model_state got=%b want=%b t=%0t", aq, eq, $time); end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  function automatic int sl(input logic [N*XW-1:0] b, input int k);
    return int'(b[k*XW +: XW]);
  endfunction

  task automatic run_ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      tick = 1'b1;
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  int cur_tab[6] = '{3, 4, 0, 1, 2, 3};
  int sc_tab[6]  = '{1, 2, 3, 3, 3, 3};

  initial begin
    int npass;
    // reset defaults
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_q_init", int'(q_init), 1);
    chk("rst_l0", sl(edge_l, 0), 284);
    chk("rst_r0", sl(edge_r, 0), 345);
    chk("rst_l3", sl(edge_l, 3), 0);
    chk("rst_r3", sl(edge_r, 3), 61);
    chk("rst_cur", int'(cur_idx), 2);
    chk("rst_score", int'(score), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // speed 1: clamp, respawn, first pass
    pulse_start();
    chk("run_q", int'(q_run), 1);
    speed = 3'd1;
    run_ticks(60);
    chk("s1_l3_clamp", sl(edge_l, 3), 0);
    chk("s1_r3_at1", sl(edge_r, 3), 1);
    run_ticks(1);
    chk("s1_l3_respawn", sl(edge_l, 3), 640);
    chk("s1_r3_respawn", sl(edge_r, 3), 701);
    run_ticks(55);
    chk("s1_r0_229", sl(edge_r, 0), 229);
    chk("s1_score0", int'(score), 0);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    chk("pass_pulse", int'(pass_pulse), 1);
    chk("pass_cur", int'(cur_idx), 3);
    chk("pass_score", int'(score), 1);
    @(negedge clk);
    chk("pass_pulse_low", int'(pass_pulse), 0);

    // pause frozen over 10 ticks
    pause = 1'b1;
    run_ticks(10);
    chk("pause_q", int'(q_pause), 1);
    chk("pause_l0", sl(edge_l, 0), 309);
    chk("pause_r0", sl(edge_r, 0), 370);
    pause = 1'b0;
    @(negedge clk);
    chk("unpause_q", int'(q_run), 1);

    // stop with tick in the same cycle
    stop = 1'b1; tick = 1'b1;
    @(negedge clk); stop = 1'b0; tick = 1'b0;
    chk("stop_q", int'(q_stop), 1);
    chk("stop_r0", sl(edge_r, 0), 370);
    chk("stop_score", int'(score), 1);
    chk("stop_cur", int'(cur_idx), 3);
    run_ticks(3);
    chk("stop_hold_r0", sl(edge_r, 0), 370);
    ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    chk("ack_q_init", int'(q_init), 1);
    @(negedge clk);
    chk("reload_r0", sl(edge_r, 0), 345);
    chk("reload_cur", int'(cur_idx), 2);
    chk("reload_score", int'(score), 0);

    // speed 3 respawn, then speed 0
    pulse_start();
    speed = 3'd3;
    run_ticks(1);
    chk("s3_r3_58", sl(edge_r, 3), 58);
    run_ticks(19);
    chk("s3_r3_1", sl(edge_r, 3), 1);
    run_ticks(1);
    chk("s3_l3_respawn", sl(edge_l, 3), 640);
    chk("s3_r3_respawn", sl(edge_r, 3), 701);
    speed = 3'd0;
    run_ticks(5);
    chk("s0_l3", sl(edge_l, 3), 640);
    chk("s0_l0", sl(edge_l, 0), 221);

    // saturation and index wrap
    stop = 1'b1;
    @(negedge clk); stop = 1'b0; ack = 1'b1;
    @(negedge clk); ack = 1'b0;
    pulse_start();
    speed = 3'd7;
    npass = 0;
    for (int t = 0; t < 1000 && npass < 6; t++) begin
      @(negedge clk);
      if (pass_pulse) begin
        chk("sat_cur", int'(cur_idx), cur_tab[npass]);
        chk("sat_score", int'(score), sc_tab[npass]);
        npass++;
      end
      tick = 1'b1;
    end
    tick = 1'b0;
    chk("sat_passes", npass, 6);
    run_ticks(4);

    // asynchronous reset mid-run
    chk("pre_async_run", int'(q_run), 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_q_init", int'(q_init), 1);
    chk("async_l0", sl(edge_l, 0), 284);
    chk("async_r0", sl(edge_r, 0), 345);
    chk("async_cur", int'(cur_idx), 2);
    chk("async_score", int'(score), 0);
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obstacle_scroller.md
# obstacle_scroller

Parametrised scrolling-obstacle position engine for the Flappy VGA datapath. It holds N obstacles, each with left and right X edges, and scrolls them leftward by a programmable step on every frame tick. Obstacles that leave the screen respawn at the right-hand edge. It tracks which obstacle is next in scope of the bird and counts passed obstacles as score. It sits between the game-control FSM (start/stop/ack, pause) and the obstacle/collision and VGA render logic, which consume its ordered edge buses.

## Interface
Parameters:
- N, 5: number of obstacles (2..8)
- XW, 10: coordinate width; SCREEN_W+OBJ_W must be < 2^XW
- OBJ_W, 61: obstacle width in pixels
- INTERVAL, 142: initial spacing between consecutive left edges
- SCREEN_W, 640: respawn left-edge X
- BIRD_X, 230: pass threshold; an obstacle is passed when its right edge < BIRD_X
- INIT_IDX, 2: initial in-scope obstacle index
- SCORE_W, 8: score counter width
- SPEED_W, 3: width of the speed input

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  leave INIT and begin scrolling
- stop  in  1  end of game (collision)
- ack  in  1  acknowledge stop and return to INIT
- pause  in  1  level; hold positions while high
- tick  in  1  one-cycle frame/move strobe
- speed  in  SPEED_W  pixels moved per tick; 0 = no motion
- edge_l  out  N*XW  left edges, ordered by scope; slot k at bits [k*XW +: XW] = obstacle (cur_idx+k) mod N
- edge_r  out  N*XW  right edges, same ordering
- cur_idx  out  clog2(N)  index of the obstacle currently in scope
- score  out  SCORE_W  passed-obstacle count, saturating
- pass_pulse  out  1  one-cycle strobe on each pass
- q_init, q_run, q_pause, q_stop  out  1 each  one-hot state flags

## Operation
- States: INIT, RUN, PAUSE, STOP. One-hot encoding. An illegal encoding recovers to INIT on the next clock.
- INIT:
  - Every cycle, reload left[i]=i*INTERVAL, right[i]=left[i]+OBJ_W, cur_idx=INIT_IDX, score=0, pass_pulse=0.
  - start=1 → RUN.
- RUN, priority order: stop > pause > tick.
  - stop=1 → STOP. Positions, score and cur_idx are frozen that cycle, even if tick=1.
  - else pause=1 → PAUSE, with no motion that cycle.
  - else on tick=1, with step=speed, apply to every obstacle i in parallel:
    - if right[i] <= step: respawn, left[i]=SCREEN_W, right[i]=SCREEN_W+OBJ_W;
    - else: right[i] -= step, and left[i] = (left[i] >= step) ? left[i]-step : 0 (clamp at 0).
- Pass detection in RUN on a tick cycle (not stopped or paused):
  - Uses the registered right[cur_idx] value from before this cycle's update.
  - If it is < BIRD_X: cur_idx = (cur_idx+1) mod N, score += 1 (saturating at 2^SCORE_W-1), pass_pulse=1.
  - At most one pass per tick.
- PAUSE: all registers hold. pause=0 → RUN. stop=1 → STOP, and stop has priority over pause release.
- STOP: all registers hold, so the score stays visible. ack=1 → INIT.
- pass_pulse is 0 in every cycle not described above.
- Arithmetic: all coordinate math is unsigned XW-bit. step is zero-extended to XW. No wrap below 0 is possible, because of the respawn and clamp rules.

## Timing
- Reset (reset=0, asynchronous):
  - state=INIT, left[i]=i*INTERVAL, right[i]=i*INTERVAL+OBJ_W, cur_idx=INIT_IDX, score=0, pass_pulse=0.
  - Outputs reflect these values immediately.
- Deassertion is synchronised externally. The first active edge after release behaves as INIT.
- Latency:
  - Registered state/position updates are visible one clk after the qualifying inputs are sampled.
  - edge_l, edge_r, q_* are combinational from registers, so zero extra latency.
- start, stop, ack, pause and tick are sampled on the rising edge of clk. No handshake hold is required beyond one cycle.
- Reset asserted mid-RUN or mid-STOP returns all state to the reset values asynchronously.

## Test plan
- Reset/defaults: hold reset=0 → q_init=1, edge_l slot0=284, edge_r slot0=345, slot3=(0,61), cur_idx=2, score=0.
- Pass at speed 1:
  - Setup: start, then speed=1 with 117 ticks.
  - After 116 ticks: edge_r slot0=229, score=0.
  - 117th tick: pass_pulse=1 for one cycle, cur_idx=3, score=1.
- Respawn and clamp at speed 1:
  - Obstacle 0 left holds 0 from the first tick.
  - After 60 ticks, right[0]=1.
  - 61st tick: left[0]=640, right[0]=701.
- Speed 3:
  - Obstacle 0 right goes 61→58→…→4→1.
  - On the tick after it reaches 1 (1 ≤ 3): respawn to (640,701).
  - speed=0 with ticks: no change.
- Pause/stop/ack:
  - pause mid-run: positions frozen across 10 ticks.
  - Raise stop while tick=1 in the same cycle → q_stop=1, positions and score unchanged.
  - ack → q_init, then full reload.
- Saturation and wrap (SCORE_W=2, N=5):
  - Run through 6 passes → score stays 3.
  - cur_idx sequence 2,3,4,0,1,2.
  - Async reset mid-run restores the defaults immediately.
